grid_player_ctrl: RTL and testbench

GRID_PLAYER_CTRL -- requirements
Module: grid_player_ctrl

---
 rtl/grid_player_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_grid_player_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_player_ctrl.sv
// Grid-based player controller: steps a player around a bounded playfield on frame
// triggers and runs a timed sword attack. Optional post-attack lockout: ATTACK_COOLDOWN_EN.
module grid_player_ctrl #(
  parameter int X_BITS          = 4,
  parameter int Y_BITS          = 4,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 15,
  parameter int Y_MIN           = 2,
  parameter int Y_MAX           = 11,
  parameter int RESET_X         = 1,
  parameter int RESET_Y         = 3,
  parameter int ATTACK_FRAMES   = 5,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [9:0]               input_data,
  output logic [X_BITS+Y_BITS-1:0] player_pos,
  output logic [1:0]               player_direction,
  output logic [1:0]               player_orientation,
  output logic [X_BITS+Y_BITS-1:0] sword_position,
  output logic                     sword_visible,
  output logic [1:0]               sword_orientation,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ATTACK   = 2'b01,
    ST_COOLDOWN = 2'b10
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [X_BITS-1:0] XMIN_L = X_BITS'(X_MIN);
  localparam logic [X_BITS-1:0] XMAX_L = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] YMIN_L = Y_BITS'(Y_MIN);
  localparam logic [Y_BITS-1:0] YMAX_L = Y_BITS'(Y_MAX);
  localparam logic [X_BITS-1:0] XRST_L = X_BITS'(RESET_X);
  localparam logic [Y_BITS-1:0] YRST_L = Y_BITS'(RESET_Y);
  localparam logic [5:0]        ATK_LAST = 6'(ATTACK_FRAMES - 1);
  localparam logic [5:0]        CD_LAST  = 6'(COOLDOWN_FRAMES - 1);

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [X_BITS-1:0] pos_x_q, pos_x_d;
  logic [Y_BITS-1:0] pos_y_q, pos_y_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        orient_q, orient_d;
  logic [X_BITS-1:0] sword_x_q, sword_x_d;
  logic [Y_BITS-1:0] sword_y_q, sword_y_d;
  logic              sword_vis_q, sword_vis_d;
  logic [1:0]        sword_dir_q, sword_dir_d;

  logic              btn_attack;
  logic              has_dir;
  logic [1:0]        pick_dir;
  logic [1:0]        eff_dir;
  logic [X_BITS-1:0] move_x, off_x;
  logic [Y_BITS-1:0] move_y, off_y;
  logic              unused_low_bits;

  assign unused_low_bits = ^input_data[4:0];

  // True when one tile further in direction d is still inside the playfield.
  function automatic logic can_step(input logic [1:0] d,
                                    input logic [X_BITS-1:0] x,
                                    input logic [Y_BITS-1:0] y);
    case (d)
      DIR_UP:    can_step = (y > YMIN_L);
      DIR_RIGHT: can_step = (x < XMAX_L);
      DIR_DOWN:  can_step = (y < YMAX_L);
      default:   can_step = (x > XMIN_L);
    endcase
  endfunction

  // Controller decode; right > left > down > up when several are held.
  always_comb begin
    btn_attack = input_data[9];
    has_dir    = |input_data[8:5];
    pick_dir   = DIR_UP;
    if (input_data[8])      pick_dir = DIR_RIGHT;
    else if (input_data[7]) pick_dir = DIR_LEFT;
    else if (input_data[6]) pick_dir = DIR_DOWN;
    eff_dir = has_dir ? pick_dir : dir_q;
  end

  // Candidate step (bound-clamped) and sword tile (one tile ahead of the player).
  always_comb begin
    move_x = pos_x_q;
    move_y = pos_y_q;
    if (can_step(pick_dir, pos_x_q, pos_y_q)) begin
      case (pick_dir)
        DIR_UP:    move_y = pos_y_q - Y_BITS'(1);
        DIR_RIGHT: move_x = pos_x_q + X_BITS'(1);
        DIR_DOWN:  move_y = pos_y_q + Y_BITS'(1);
        default:   move_x = pos_x_q - X_BITS'(1);
      endcase
    end
    off_x = pos_x_q;
    off_y = pos_y_q;
    case (eff_dir)
      DIR_UP:    off_y = pos_y_q - Y_BITS'(1);
      DIR_RIGHT: off_x = pos_x_q + X_BITS'(1);
      DIR_DOWN:  off_y = pos_y_q + Y_BITS'(1);
      default:   off_x = pos_x_q - X_BITS'(1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_d       = dir_q;
    orient_d    = orient_q;
    sword_x_d   = sword_x_q;
    sword_y_d   = sword_y_q;
    sword_vis_d = sword_vis_q;
    sword_dir_d = sword_dir_q;
    if (trigger) begin
      case (state_q)
        ST_IDLE: begin
          if (btn_attack) begin
            dir_d = eff_dir;
            if (eff_dir[0]) orient_d = eff_dir;
            sword_dir_d = eff_dir;
            sword_x_d   = off_x;
            sword_y_d   = off_y;
            // The sword is drawn only if its tile is on the playfield.
            sword_vis_d = can_step(eff_dir, pos_x_q, pos_y_q);
            cnt_d       = 6'd0;
            state_d     = ST_ATTACK;
          end else if (has_dir) begin
            dir_d   = pick_dir;
            if (pick_dir[0]) orient_d = pick_dir;
            pos_x_d = move_x;
            pos_y_d = move_y;
          end
        end
        ST_ATTACK: begin
          if (cnt_q == ATK_LAST) begin
            sword_vis_d = 1'b0;
            cnt_d       = 6'd0;
`ifdef ATTACK_COOLDOWN_EN
            state_d     = ST_COOLDOWN;
`else
            state_d     = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_COOLDOWN: begin
          if (has_dir) begin
            dir_d   = pick_dir;
            if (pick_dir[0]) orient_d = pick_dir;
            pos_x_d = move_x;
            pos_y_d = move_y;
          end
          if (cnt_q == CD_LAST) begin
            cnt_d   = 6'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      pos_x_q     <= XRST_L;
      pos_y_q     <= YRST_L;
      dir_q       <= DIR_RIGHT;
      orient_q    <= DIR_RIGHT;
      sword_x_q   <= '0;
      sword_y_q   <= '0;
      sword_vis_q <= 1'b0;
      sword_dir_q <= DIR_RIGHT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      orient_q    <= orient_d;
      sword_x_q   <= sword_x_d;
      sword_y_q   <= sword_y_d;
      sword_vis_q <= sword_vis_d;
      sword_dir_q <= sword_dir_d;
    end
  end

  assign player_pos         = {pos_x_q, pos_y_q};
  assign player_direction   = dir_q;
  assign player_orientation = orient_q;
  assign sword_position     = {sword_x_q, sword_y_q};
  assign sword_visible      = sword_vis_q;
  assign sword_orientation  = sword_dir_q;
  assign state              = state_q;

endmodule

// File: tb/tb_grid_player_ctrl.sv
// Bench for grid_player_ctrl: directed vector table, hand-written attack/cooldown/reset
// sequences, then random frames checked against a coordinate-level reference model.
module tb_grid_player_ctrl;

  localparam int XMIN = 0, XMAX = 15, YMIN = 2, YMAX = 11;
  localparam int AFR = 5, CFR = 4;
  localparam logic [9:0] B_ATK = 10'h200, B_R = 10'h100, B_L = 10'h080,
                         B_D = 10'h040, B_U = 10'h020;
`ifdef ATTACK_COOLDOWN_EN
  localparam logic [1:0] ATK_EXIT = 2'b10;
`else
  localparam logic [1:0] ATK_EXIT = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [9:0] input_data = '0;
  logic [7:0] player_pos, sword_position;
  logic [1:0] player_direction, player_orientation, sword_orientation, state;
  logic       sword_visible;

  grid_player_ctrl dut (
    .clk(clk), .reset(reset), .trigger(trigger), .input_data(input_data),
    .player_pos(player_pos), .player_direction(player_direction),
    .player_orientation(player_orientation), .sword_position(sword_position),
    .sword_visible(sword_visible), .sword_orientation(sword_orientation), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer coordinates and frame countdowns.
  int mx, my, mdir, morient, msx, msy, mvis, msdir, mstate, att_left, cd_left;

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int dyf(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction
  function automatic bit inside_field(input int x, input int y);
    return (x >= XMIN) && (x <= XMAX) && (y >= YMIN) && (y <= YMAX);
  endfunction

  task automatic model_reset();
    mx = 1; my = 3; mdir = 1; morient = 1;
    msx = 0; msy = 0; mvis = 0; msdir = 1;
    mstate = 0; att_left = 0; cd_left = 0;
  endtask

  task automatic model_move(input int nd);
    mdir = nd;
    if (nd == 1 || nd == 3) morient = nd;
    if (inside_field(mx + dxf(nd), my + dyf(nd))) begin
      mx = mx + dxf(nd);
      my = my + dyf(nd);
    end
  endtask

  task automatic model_trigger(input logic [9:0] din);
    bit has;
    int nd;
    has = din[8] | din[7] | din[6] | din[5];
    nd  = din[8] ? 1 : din[7] ? 3 : din[6] ? 2 : 0;
    if (mstate == 0) begin
      if (din[9]) begin
        if (has) begin
          mdir = nd;
          if (nd == 1 || nd == 3) morient = nd;
        end
        msdir = mdir;
        msx = (mx + dxf(mdir) + 16) % 16;
        msy = (my + dyf(mdir) + 16) % 16;
        mvis = inside_field(mx + dxf(mdir), my + dyf(mdir)) ? 1 : 0;
        mstate = 1;
        att_left = AFR;
      end else if (has) begin
        model_move(nd);
      end
    end else if (mstate == 1) begin
      att_left--;
      if (att_left == 0) begin
        mvis = 0;
`ifdef ATTACK_COOLDOWN_EN
        mstate = 2;
        cd_left = CFR;
`else
        mstate = 0;
`endif
      end
    end else begin
      if (has) model_move(nd);
      cd_left--;
      if (cd_left == 0) mstate = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pos"},      32'(player_pos),         32'(mx * 16 + my));
    chk({tag, " dir"},      32'(player_direction),   32'(mdir));
    chk({tag, " orient"},   32'(player_orientation), 32'(morient));
    chk({tag, " sword_pos"},32'(sword_position),     32'(msx * 16 + msy));
    chk({tag, " sword_vis"},32'(sword_visible),      32'(mvis));
    chk({tag, " sword_dir"},32'(sword_orientation),  32'(msdir));
    chk({tag, " state"},    32'(state),              32'(mstate));
  endtask

  task automatic step(input logic trig, input logic [9:0] din);
    trigger = trig;
    input_data = din;
    @(posedge clk);
    #1;
    if (trig) model_trigger(din);
    trigger = 1'b0;
    input_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [9:0] din;
    logic [7:0] pos;
    logic [1:0] dir;
    logic [1:0] orient;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{B_R,               8'h23, 2'b01, 2'b01};
    vecs[1] = '{B_L | 10'h01F,     8'h13, 2'b11, 2'b11};
    vecs[2] = '{B_L,               8'h03, 2'b11, 2'b11};
    vecs[3] = '{B_U,               8'h02, 2'b00, 2'b11};
    vecs[4] = '{B_U,               8'h02, 2'b00, 2'b11};
    vecs[5] = '{B_R | B_U,         8'h12, 2'b01, 2'b01};
    vecs[6] = '{B_D,               8'h13, 2'b10, 2'b01};
    vecs[7] = '{B_L | B_D,         8'h03, 2'b11, 2'b11};
    vecs[8] = '{B_L,               8'h03, 2'b11, 2'b11};

    model_reset();
    #12;
    reset = 1'b0;
    chk("reset pos",       32'(player_pos),         32'h13);
    chk("reset dir",       32'(player_direction),   32'h1);
    chk("reset orient",    32'(player_orientation), 32'h1);
    chk("reset sword_pos", 32'(sword_position),     32'h0);
    chk("reset sword_vis", 32'(sword_visible),      32'h0);
    chk("reset sword_dir", 32'(sword_orientation),  32'h1);
    chk("reset state",     32'(state),              32'h0);

    // Non-trigger edges must not change anything.
    step(1'b0, B_R);
    step(1'b0, B_ATK);
    chk("idle no-trigger pos",   32'(player_pos), 32'h13);
    chk("idle no-trigger state", 32'(state),      32'h0);

    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].din);
      chk($sformatf("vec%0d pos", i),    32'(player_pos),         32'(vecs[i].pos));
      chk($sformatf("vec%0d dir", i),    32'(player_direction),   32'(vecs[i].dir));
      chk($sformatf("vec%0d orient", i), 32'(player_orientation), 32'(vecs[i].orient));
      chk($sformatf("vec%0d state", i),  32'(state),              32'h0);
    end

    // Attack to the left from 0x13: sword visible for exactly five frames.
    do_reset();
    step(1'b1, B_ATK | B_L);
    chk("atk sword_pos", 32'(sword_position),     32'h03);
    chk("atk sword_vis", 32'(sword_visible),      32'h1);
    chk("atk sword_dir", 32'(sword_orientation),  32'h3);
    chk("atk orient",    32'(player_orientation), 32'h3);
    chk("atk state",     32'(state),              32'h1);
    step(1'b0, B_R);
    chk("atk no-trigger vis", 32'(sword_visible), 32'h1);
    for (int i = 1; i < AFR; i++) begin
      step(1'b1, B_R | B_ATK);
      chk($sformatf("atk frame%0d vis", i),   32'(sword_visible), 32'h1);
      chk($sformatf("atk frame%0d state", i), 32'(state),        32'h1);
      chk($sformatf("atk frame%0d pos", i),   32'(player_pos),    32'h13);
    end
    step(1'b1, B_R);
    chk("atk end vis",       32'(sword_visible),     32'h0);
    chk("atk end state",     32'(state),             32'(ATK_EXIT));
    chk("atk end pos",       32'(player_pos),        32'h13);
    chk("atk end sword_pos", 32'(sword_position),    32'h03);
    chk("atk end sword_dir", 32'(sword_orientation), 32'h3);

`ifdef ATTACK_COOLDOWN_EN
    step(1'b1, B_ATK | B_R);
    chk("cd move pos",   32'(player_pos), 32'h23);
    chk("cd move state", 32'(state),      32'h2);
    chk("cd move vis",   32'(sword_visible), 32'h0);
    step(1'b1, B_ATK);
    chk("cd atk ignored", 32'(state), 32'h2);
    step(1'b1, 10'h000);
    chk("cd frame3 state", 32'(state), 32'h2);
    step(1'b1, B_ATK);
    chk("cd done state", 32'(state),         32'h0);
    chk("cd done vis",   32'(sword_visible), 32'h0);
`endif
    check_model("after first attack");

    // Attack off the left edge: invisible, but still a full-length attack.
    do_reset();
    step(1'b1, B_L);
    step(1'b1, B_L);
    chk("edge pos", 32'(player_pos), 32'h03);
    step(1'b1, B_ATK);
    chk("edge vis",   32'(sword_visible), 32'h0);
    chk("edge state", 32'(state),         32'h1);
    for (int i = 1; i < AFR; i++) begin
      step(1'b1, B_R);
      chk($sformatf("edge frame%0d state", i), 32'(state),         32'h1);
      chk($sformatf("edge frame%0d vis", i),   32'(sword_visible), 32'h0);
      chk($sformatf("edge frame%0d pos", i),   32'(player_pos),    32'h03);
    end
    step(1'b1, B_R);
    chk("edge end state", 32'(state),      32'(ATK_EXIT));
    chk("edge end pos",   32'(player_pos), 32'h03);
    check_model("edge end");

    // Asynchronous reset between triggers mid-attack.
    do_reset();
    step(1'b1, B_ATK | B_L);
    step(1'b1, 10'h000);
    step(1'b1, 10'h000);
    reset = 1'b1;
    #2;
    chk("midatk reset vis",   32'(sword_visible),  32'h0);
    chk("midatk reset state", 32'(state),          32'h0);
    chk("midatk reset pos",   32'(player_pos),     32'h13);
    chk("midatk reset spos",  32'(sword_position), 32'h0);
    reset = 1'b0;
    model_reset();
    step(1'b0, 10'h000);
    check_model("post reset");

    // Random frames against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [9:0] din;
      logic       trig;
      din = 10'($urandom);
      if ($urandom_range(0, 99) < 75) din[9] = 1'b0;
      trig = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      step(trig, din);
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
